// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and frame helpers for the UART transmitter
//
// Contents:
//   PAR_NONE / PAR_EVEN / PAR_ODD : run-time parity-mode codes (code 3 behaves as none)
//   MIN_CLKS_PER_BIT              : smallest usable bit period; shorter requests are clamped
//   state_e                       : transmitter FSM state encoding
//   parity_enabled()              : true when a parity bit is appended to the frame
//   frame_bit_periods()           : frame length in bit periods for a given configuration
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int MIN_CLKS_PER_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // start + data + optional parity + one or two stop bits
    function automatic int frame_bit_periods(input int data_bits,
                                             input logic [1:0] mode,
                                             input logic stop2);
        return 1 + data_bits + (parity_enabled(mode) ? 1 : 0) + (stop2 ? 2 : 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous word FIFO feeding the UART transmitter
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset; empties the FIFO
//   push       in   write request; ignored while full
//   push_data  in   WIDTH-bit word to write
//   pop        in   read request; ignored while empty
//   pop_data   out  word at the head of the FIFO (valid while !empty)
//   full       out  DEPTH words held
//   empty      out  no words held
//   level      out  number of words held, 0..DEPTH
module uart_tx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Flags come from the registered count only, so a word pushed this
    // cycle cannot be popped until the following edge.
    assign full     = (count_q == LVL_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with input FIFO and run-time frame config
//
// Ports:
//   clk             in   system clock
//   reset_n         in   asynchronous active-low reset; aborts any frame, empties FIFO
//   i_valid         in   producer has a word on i_data
//   i_data          in   DATA_BITS word to send, LSB first
//   o_ready         out  FIFO can accept a word (transfer on i_valid & o_ready)
//   i_clks_per_bit  in   bit period in clk cycles; 0 and 1 behave as 2
//   i_parity_mode   in   0 none, 1 even, 2 odd, 3 none
//   i_stop2         in   0 one stop bit, 1 two stop bits
//   o_tx            out  serial line, idle high
//   o_active        out  high while any frame bit is on the line
//   o_done          out  one-cycle pulse after each completed frame
//   o_fifo_level    out  words currently queued
module uart_tx_param
    import uart_pkg::*;
#(
    parameter  int DATA_BITS  = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int DIV_W      = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    input  logic [DIV_W-1:0]     i_clks_per_bit,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_stop2,
    output logic                 o_tx,
    output logic                 o_active,
    output logic                 o_done,
    output logic [LVL_W-1:0]     o_fifo_level
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int CNT_W = DIV_W + 1;

    // FIFO interface
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LVL_W-1:0]     fifo_level;

    // Frame state
    state_e               state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    // Configuration latched at the start of each frame
    logic [DIV_W-1:0]     cpb_q, cpb_d;
    logic [1:0]           par_q, par_d;
    logic                 stop2_q, stop2_d;

    logic [DIV_W-1:0]     cpb_new;
    logic                 bit_last;
    logic                 stop_last;
    logic                 parity_bit;
    logic                 start_frame;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (i_valid),
        .push_data (i_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign o_ready      = ~fifo_full;
    assign o_fifo_level = fifo_level;
    assign o_tx         = tx_q;
    assign o_active     = active_q;
    assign o_done       = done_q;

    assign cpb_new = (i_clks_per_bit < DIV_W'(MIN_CLKS_PER_BIT))
                   ? DIV_W'(MIN_CLKS_PER_BIT) : i_clks_per_bit;

    // The counter is one bit wider than the divisor so the double stop
    // period (2*CPB) still fits.
    assign bit_last  = (cnt_q == ({1'b0, cpb_q} - CNT_W'(1)));
    assign stop_last = (cnt_q == ((stop2_q ? {cpb_q, 1'b0} : {1'b0, cpb_q}) - CNT_W'(1)));

    assign parity_bit = (^data_q) ^ (par_q == PAR_ODD);

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        active_d    = active_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        data_d      = data_q;
        cpb_d       = cpb_q;
        par_d       = par_q;
        stop2_d     = stop2_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end

            ST_START: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        if (parity_enabled(par_q)) begin
                            tx_d    = parity_bit;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = data_q[idx_q + IDX_W'(1)];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (stop_last) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (!fifo_empty) begin
                        // Next start bit follows the last stop cycle directly.
                        start_frame = 1'b1;
                    end else begin
                        tx_d     = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end

            default: begin
                tx_d     = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
        endcase

        // Shared frame launch from IDLE or from the end of STOP.
        if (start_frame) begin
            fifo_pop = 1'b1;
            data_d   = fifo_data;
            cpb_d    = cpb_new;
            par_d    = i_parity_mode;
            stop2_d  = i_stop2;
            tx_d     = 1'b0;
            active_d = 1'b1;
            cnt_d    = '0;
            state_d  = ST_START;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            tx_q     <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            cpb_q    <= DIV_W'(MIN_CLKS_PER_BIT);
            par_q    <= PAR_NONE;
            stop2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            active_q <= active_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            cpb_q    <= cpb_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed self-checking bench for uart_tx_param
module tb_uart_tx_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [7:0]  i_data = '0;
    logic        o_ready;
    logic [15:0] i_clks_per_bit = 16'd4;
    logic [1:0]  i_parity_mode = 2'd0;
    logic        i_stop2 = 1'b0;
    logic        o_tx;
    logic        o_active;
    logic        o_done;
    logic [2:0]  o_fifo_level;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_param #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .o_ready        (o_ready),
        .i_clks_per_bit (i_clks_per_bit),
        .i_parity_mode  (i_parity_mode),
        .i_stop2        (i_stop2),
        .o_tx           (o_tx),
        .o_active       (o_active),
        .o_done         (o_done),
        .o_fifo_level   (o_fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a free slot, then drives one word for one edge.
    task automatic push(input logic [7:0] d);
        int t;
        t = 0;
        if (!o_ready) i_valid = 1'b0;
        while (!o_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) chk("push_ready_timeout", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_data  = d;
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        int t;
        t = 0;
        while (o_tx !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (o_tx !== 1'b0) chk({tag, "_start_timeout"}, 32'(o_tx), 32'd0);
    endtask

    // Entered on the negedge of start-bit cycle 0; returns on the negedge of
    // the last stop cycle. par < 0 means no parity bit is expected.
    task automatic expect_frame(input logic [7:0] d, input int cpb, input int par,
                                input bit stop2, input string tag);
        logic [11:0] seq;
        int nb;
        seq    = '0;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1 + i] = d[i];
        nb = 9;
        if (par >= 0) begin
            seq[9] = par[0];
            nb = 10;
        end
        seq[nb] = 1'b1;
        nb++;
        if (stop2) begin
            seq[nb] = 1'b1;
            nb++;
        end
        for (int c = 0; c < nb * cpb; c++) begin
            if (c > 0) @(negedge clk);
            chk({tag, "_tx"}, 32'(o_tx), 32'(seq[c / cpb]));
            chk({tag, "_active"}, 32'(o_active), 32'd1);
            if (c > 0) chk({tag, "_done_early"}, 32'(o_done), 32'd0);
        end
    endtask

    logic [7:0] words [6];

    initial begin
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_active", 32'(o_active), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_level", 32'(o_fifo_level), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // CPB=4, even parity, 1 stop, 0xA5: parity 0, 44 cycles
        i_clks_per_bit = 16'd4; i_parity_mode = 2'd1; i_stop2 = 1'b0;
        push(8'hA5);
        i_valid = 1'b0;
        chk("t1_lat_idle", 32'(o_tx), 32'd1);
        chk("t1_level", 32'(o_fifo_level), 32'd1);
        @(negedge clk);
        chk("t1_lat_start", 32'(o_tx), 32'd0);
        expect_frame(8'hA5, 4, 0, 1'b0, "t1");
        @(negedge clk);
        chk("t1_done", 32'(o_done), 32'd1);
        chk("t1_idle_tx", 32'(o_tx), 32'd1);
        chk("t1_idle_active", 32'(o_active), 32'd0);
        @(negedge clk);
        chk("t1_done_once", 32'(o_done), 32'd0);

        // Odd parity, 2 stops, 0xA5: parity 1, 48 cycles
        i_parity_mode = 2'd2; i_stop2 = 1'b1;
        push(8'hA5);
        i_valid = 1'b0;
        wait_start("t2");
        expect_frame(8'hA5, 4, 1, 1'b1, "t2");
        @(negedge clk);
        chk("t2_done", 32'(o_done), 32'd1);
        chk("t2_idle_active", 32'(o_active), 32'd0);

        // No parity, CPB=3, 0x00 then 0xFF back to back: 30-cycle frames
        i_clks_per_bit = 16'd3; i_parity_mode = 2'd0; i_stop2 = 1'b0;
        push(8'h00);
        push(8'hFF);
        i_valid = 1'b0;
        wait_start("t3");
        expect_frame(8'h00, 3, -1, 1'b0, "t3a");
        @(negedge clk);
        chk("t3_done_a", 32'(o_done), 32'd1);
        chk("t3_gapless", 32'(o_tx), 32'd0);
        expect_frame(8'hFF, 3, -1, 1'b0, "t3b");
        @(negedge clk);
        chk("t3_done_b", 32'(o_done), 32'd1);
        chk("t3_idle_active", 32'(o_active), 32'd0);

        // Six words pushed every cycle into a depth-4 FIFO, CPB=2
        i_clks_per_bit = 16'd2;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(words[i]);
                    if (i == 4) begin
                        chk("t4_full_level", 32'(o_fifo_level), 32'd4);
                        chk("t4_full_ready", 32'(o_ready), 32'd0);
                    end
                end
                i_valid = 1'b0;
            end
            begin
                wait_start("t4");
                for (int k = 0; k < 6; k++) begin
                    expect_frame(words[k], 2, -1, 1'b0, $sformatf("t4_w%0d", k));
                    @(negedge clk);
                    chk("t4_done", 32'(o_done), 32'd1);
                    chk("t4_next_tx", 32'(o_tx), (k < 5) ? 32'd0 : 32'd1);
                end
                chk("t4_end_level", 32'(o_fifo_level), 32'd0);
                chk("t4_end_active", 32'(o_active), 32'd0);
            end
        join

        // Divisor 0 behaves as 2; a mid-frame change to 8 applies to the next frame
        i_clks_per_bit = 16'd0;
        push(8'hA5);
        push(8'h3C);
        i_valid = 1'b0;
        fork
            begin
                wait_start("t5");
                expect_frame(8'hA5, 2, -1, 1'b0, "t5a");
                @(negedge clk);
                chk("t5_done_a", 32'(o_done), 32'd1);
                chk("t5_gapless", 32'(o_tx), 32'd0);
                expect_frame(8'h3C, 8, -1, 1'b0, "t5b");
            end
            begin
                repeat (6) @(negedge clk);
                i_clks_per_bit = 16'd8;
            end
        join
        @(negedge clk);
        chk("t5_done_b", 32'(o_done), 32'd1);
        chk("t5_idle_tx", 32'(o_tx), 32'd1);

        // Reset during data bit 3 with two words queued
        i_clks_per_bit = 16'd4;
        push(8'h52);
        push(8'h11);
        push(8'h22);
        i_valid = 1'b0;
        wait_start("t6");
        repeat (17) @(negedge clk);
        chk("t6_pre_tx", 32'(o_tx), 32'd0);
        chk("t6_pre_level", 32'(o_fifo_level), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_tx", 32'(o_tx), 32'd1);
        chk("t6_rst_active", 32'(o_active), 32'd0);
        chk("t6_rst_level", 32'(o_fifo_level), 32'd0);
        chk("t6_rst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("t6_post_tx", 32'(o_tx), 32'd1);
            chk("t6_post_active", 32'(o_active), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8-bit/even-parity transmitter.
- Data width is a parameter; clocks-per-bit, parity mode and stop-bit count are set at run time.
- An internal byte FIFO with a ready/valid input lets frames go out back-to-back with no idle gap.
- Sits between the system bus/loopback logic and the FPGA TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
- FIFO_DEPTH, 4, entries in the input FIFO; power of 2, >=2.
- DIV_W, 16, width of the run-time clocks-per-bit input.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  producer has a word on i_data.
- i_data  in  DATA_BITS  word to transmit.
- o_ready  out  1  FIFO can accept; a transfer occurs on an edge where i_valid & o_ready.
- i_clks_per_bit  in  DIV_W  bit period in clk cycles; values 0/1 are treated as 2.
- i_parity_mode  in  2  0=none, 1=even, 2=odd, 3=treated as none.
- i_stop2  in  1  0=one stop bit, 1=two stop bits.
- o_tx  out  1  serial line; idle high.
- o_active  out  1  high while any frame bit is on the line.
- o_done  out  1  one-cycle pulse per completed frame.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently queued.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset_n low asynchronously forces: o_tx=1, o_active=0, o_done=0, FIFO empty (o_fifo_level=0), state=IDLE, counters=0.
  - o_ready=1 after reset (= !full, combinational from the FIFO count).
  - Reset mid-frame aborts the frame immediately: line goes high and queued data is discarded.
- FIFO:
  - Push on i_valid & o_ready.
  - Pop only when non-empty before the edge, so there is no same-cycle bypass; a push into an empty FIFO is visible to the FSM on the next edge.
  - Push and pop in the same cycle: level unchanged.
  - When full, o_ready=0 and i_valid is ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - o_tx=1.
  - If the FIFO is non-empty: pop into the shift register; latch i_clks_per_bit (clamped), i_parity_mode and i_stop2 for the whole frame; o_tx<=0; o_active<=1; counter<=0; go to START.
  - Configuration changes mid-frame have no effect until the next frame.
- Latency: word accepted at edge N (FIFO previously empty, FSM idle) -> start bit on o_tx from edge N+1.
- Bit timing:
  - Each bit lasts exactly CPB cycles, where CPB is the latched clamped divisor.
  - The counter runs 0..CPB-1; the bit advances when counter==CPB-1.
- START: one bit period at 0, then DATA with index=0.
- DATA:
  - o_tx = data[index] for index 0..DATA_BITS-1.
  - Then go to PARITY if parity mode is 1/2, otherwise straight to STOP.
- PARITY:
  - Even mode sends the XOR of the DATA_BITS data bits; odd mode sends its inverse.
  - Then go to STOP.
- STOP:
  - o_tx=1 for CPB cycles, or 2*CPB cycles when the latched stop2=1.
  - On the final cycle: o_done<=1 (high for exactly the next cycle).
  - If the FIFO is non-empty: pop, latch config, o_tx<=0, go to START. o_active stays 1, giving a contiguous line with no idle cycle.
  - Otherwise: o_active<=0, go to IDLE.
- Frame length: (1 + DATA_BITS + P + S) * CPB cycles, where P is 0/1 and S is 1/2.
- Counters: counter is DIV_W+1 bits wide to cover 2*CPB; index is $clog2(DATA_BITS) bits wide.
- Illegal state encoding: return to IDLE with o_tx=1.

Decomposition:
- Shared package uart_pkg holds:
  - parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - the FSM state encoding;
  - MIN_CLKS_PER_BIT=2;
  - a function computing frame length in bit periods.
- One sub-module, uart_tx_fifo: synchronous FIFO, parametrised by WIDTH/DEPTH, with async active-low reset and level output.
- The FSM and shift logic stay in uart_tx_param.

Test Plan:
- CPB=4, even parity, 1 stop, push 0xA5 -> o_tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 cycles; 44 cycles total; o_done one pulse; o_active low afterwards.
- Same setup with odd parity, 2 stops, 0xA5 -> parity bit 1, stop held 8 cycles, 48-cycle frame.
- Parity none, DATA_BITS=8, CPB=3, push 0x00 then 0xFF on consecutive cycles -> two 30-cycle frames with no idle gap; o_done pulses 30 cycles apart; o_active continuously high.
- Push 6 words every cycle, FIFO_DEPTH=4 -> o_ready drops once the level hits 4; all 6 words are transmitted in order and nothing is lost; o_fifo_level returns to 0.
- i_clks_per_bit=0 -> every bit lasts 2 cycles; changing i_clks_per_bit to 8 mid-frame leaves the current frame at 2 and applies 8 to the next frame.
- reset_n low during the DATA bit 3 period with 2 words queued -> o_tx=1, o_active=0, o_fifo_level=0 immediately; after release the line stays idle high.
